// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads to instruction memory and
// queues returned words with their PC for decode; redirects flush the queue and drop stale replies.
module fetch_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   exp_pc_q, exp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   hold_data_q, hold_data_d;
    logic [31:0]   hold_pc_q, hold_pc_d;
    logic [31:0]   buf_data_q [DEPTH];
    logic [31:0]   buf_pc_q   [DEPTH];

    logic [CW:0]   used;
    logic [CW:0]   pending;
    logic          req_fire;
    logic          push;
    logic          pop;

    assign inst_valid    = (count_q != '0);
    assign inst_data     = inst_valid ? buf_data_q[rd_ptr_q] : hold_data_q;
    assign inst_pc       = inst_valid ? buf_pc_q[rd_ptr_q]   : hold_pc_q;
    assign imem_req_addr = fetch_pc_q;

    always_comb begin
        used    = {1'b0, count_q} + {1'b0, inflight_q} + {1'b0, discard_q};
        pending = {1'b0, discard_q} + {1'b0, inflight_q};
        // Credit covers queued words plus every outstanding reply, stale or not.
        imem_req_valid = reset && !halt && !redirect_valid && (used < (CW + 1)'(DEPTH));
        req_fire = imem_req_valid && imem_req_ready;
        push     = imem_resp_valid && !redirect_valid && (discard_q == '0) && (inflight_q != '0);
        pop      = inst_valid && inst_ready && !redirect_valid;

        fetch_pc_d  = fetch_pc_q;
        exp_pc_d    = exp_pc_q;
        count_d     = count_q;
        inflight_d  = inflight_q;
        discard_d   = discard_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        hold_data_d = hold_data_q;
        hold_pc_d   = hold_pc_q;

        if (inst_valid) begin
            hold_data_d = buf_data_q[rd_ptr_q];
            hold_pc_d   = buf_pc_q[rd_ptr_q];
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            exp_pc_d   = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            inflight_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // A reply arriving with the redirect retires one of the now-stale slots.
            discard_d  = CW'(pending - {{CW{1'b0}}, (imem_resp_valid && (pending != '0))});
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_resp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                exp_pc_d = exp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(push);
            count_d    = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            exp_pc_q    <= RESET_PC;
            count_q     <= '0;
            inflight_q  <= '0;
            discard_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hold_data_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            exp_pc_q    <= exp_pc_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_data_q <= hold_data_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    // Storage needs no reset: it is only visible through the count-gated head mux.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= imem_resp_data;
            buf_pc_q[wr_ptr_q]   <= exp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model plus a stream-level reference that tags
// requests with a redirect epoch and expects decode to see exactly the live words in order.
module tb_fetch_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] epoch;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halt = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    // Memory knobs and reference state.
    logic        mem_hold = 1'b0;
    logic        resp_rand = 1'b0;
    logic        spurious = 1'b0;
    req_t        mq[$];
    ent_t        fq[$];
    ent_t        last_head = '0;
    logic [31:0] m_fetch_pc = RESET_PC;
    logic [31:0] epoch = '0;

    // Values sampled at the falling edge of the last tick.
    logic        s_on = 1'b0;
    logic        s_req = 1'b0;
    logic        s_req_valid = 1'b0;
    logic [31:0] s_addr = '0;
    logic        s_resp = 1'b0;
    logic        s_redir = 1'b0;
    logic [31:0] s_rpc = '0;
    logic        s_iready = 1'b0;
    logic        s_inst_valid = 1'b0;
    logic [31:0] s_inst_pc = '0;

    int n_checks = 0;
    int n_fail = 0;

    fetch_prefetch_unit #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // One clock: drive memory reply, score DUT outputs at negedge, advance the reference at posedge.
    task automatic tick();
        req_t r;
        ent_t h;
        logic exp_rv;
        if (spurious) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = 32'h0BAD_F00D;
        end else if (mq.size() > 0 && !mem_hold && (!resp_rand || $urandom_range(1, 0) == 1)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_of(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom();
        end
        @(negedge clk);
        s_on = reset;
        if (reset) begin
            exp_rv = !halt && !redirect_valid && ((mq.size() + fq.size()) < int'(DEPTH));
            n_checks++;
            if (imem_req_valid !== exp_rv) begin
                n_fail++;
                $display("FAIL req_valid @%0t: got %b want %b", $time, imem_req_valid, exp_rv);
            end
            n_checks++;
            if (imem_req_addr !== m_fetch_pc) begin
                n_fail++;
                $display("FAIL req_addr @%0t: got %h want %h", $time, imem_req_addr, m_fetch_pc);
            end
            n_checks++;
            if (inst_valid !== (fq.size() != 0)) begin
                n_fail++;
                $display("FAIL inst_valid @%0t: got %b want %b", $time, inst_valid, fq.size() != 0);
            end
            h = (fq.size() != 0) ? fq[0] : last_head;
            n_checks++;
            if (inst_pc !== h.pc || inst_data !== h.data) begin
                n_fail++;
                $display("FAIL head @%0t: got pc %h data %h want pc %h data %h", $time, inst_pc,
                         inst_data, h.pc, h.data);
            end
            last_head    = h;
            s_req        = imem_req_valid && imem_req_ready;
            s_req_valid  = imem_req_valid;
            s_addr       = imem_req_addr;
            s_resp       = imem_resp_valid;
            s_redir      = redirect_valid;
            s_rpc        = redirect_pc;
            s_iready     = inst_ready;
            s_inst_valid = inst_valid;
            s_inst_pc    = inst_pc;
        end
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            fq.delete();
            last_head  = '0;
            m_fetch_pc = RESET_PC;
            epoch      = '0;
        end else if (s_on) begin
            if (s_redir) begin
                fq.delete();
                if (s_resp && mq.size() > 0) void'(mq.pop_front());
                epoch++;
                m_fetch_pc = s_rpc & ~32'h3;
            end else begin
                if (s_iready && fq.size() > 0) void'(fq.pop_front());
                if (s_resp && mq.size() > 0) begin
                    r = mq.pop_front();
                    if (r.epoch == epoch) fq.push_back('{pc: r.addr, data: word_of(r.addr)});
                end
                if (s_req) begin
                    mq.push_back('{addr: m_fetch_pc, epoch: epoch});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        bit done = 0;
        halt = 1'b1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; mem_hold = 1'b0; resp_rand = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            done = (mq.size() == 0 && fq.size() == 0);
        end
        tick();
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain: pending %0d queued %0d want 0 0", mq.size(), fq.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst_data !== 32'h0 ||
            inst_pc !== 32'h0 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_outputs: got iv %b rv %b d %h pc %h a %h want 0 0 0 0 %h",
                     inst_valid, imem_req_valid, inst_data, inst_pc, imem_req_addr, RESET_PC);
        end
        tick();
        tick();
        reset = 1'b1;
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        tick();
        tick();
        n_checks++;
        if (s_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_ignored: got inst_valid %b want 0", s_inst_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] first = '0, prev = '0;
        bit got = 0, bad = 0;
        int nv = 0;
        halt = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_req && !got) begin first = s_addr; got = 1; end
            if (i >= 10 && s_inst_valid) begin
                if (nv > 0 && s_inst_pc !== prev + 32'd4) bad = 1;
                prev = s_inst_pc;
                nv++;
            end
        end
        n_checks++;
        if (!got || first !== RESET_PC) begin
            n_fail++;
            $display("FAIL stream_first_addr: got %h want %h", first, RESET_PC);
        end
        n_checks++;
        if (nv != 10 || bad) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d words (order bad=%0d) want 10 in order", nv, bad);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] first = '0;
        logic [31:0] p0 = '0;
        int nreq = 0, npop = 0;
        bit bad = 0, resumed = 0;
        drain();
        halt = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_req) begin
                if (nreq == 0) first = s_addr;
                nreq++;
            end
        end
        n_checks++;
        if (nreq != int'(DEPTH)) begin
            n_fail++;
            $display("FAIL credit_limit: got %0d requests want %0d", nreq, DEPTH);
        end
        n_checks++;
        if (s_req_valid !== 1'b0 || s_inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_state: got req_valid %b inst_valid %b want 0 1", s_req_valid,
                     s_inst_valid);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && npop < 4; i++) begin
            tick();
            if (s_req) resumed = 1;
            if (s_inst_valid) begin
                if (npop == 0) p0 = s_inst_pc;
                else if (s_inst_pc !== p0 + 32'(4 * npop)) bad = 1;
                npop++;
            end
        end
        n_checks++;
        if (npop != 4 || bad || p0 !== first) begin
            n_fail++;
            $display("FAIL drain_order: got %0d words from %h (bad=%0d) want 4 from %h", npop, p0,
                     bad, first);
        end
        tick();
        n_checks++;
        if (!(resumed || s_req)) begin
            n_fail++;
            $display("FAIL resume_after_drain: got no request want request");
        end
    endtask

    task automatic test_redirect();
        int nreq = 0;
        bit seen = 0;
        drain();
        mem_hold = 1'b1; halt = 1'b0;
        tick(); if (s_req) nreq++;
        tick(); if (s_req) nreq++;
        n_checks++;
        if (nreq != 2) begin
            n_fail++;
            $display("FAIL redirect_setup: got %0d in flight want 2", nreq);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_addr: got %b %h want 1 00000100", s_req_valid, s_addr);
        end
        mem_hold = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = s_inst_valid;
        end
        n_checks++;
        if (!seen || s_inst_pc !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_first_pc: got %h (valid %0d) want 00000100", s_inst_pc, seen);
        end
    endtask

    task automatic test_collision();
        bit seen = 0;
        drain();
        halt = 1'b0; inst_ready = 1'b0;
        tick();
        tick();
        mem_hold = 1'b1;
        tick();
        tick();
        mem_hold = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (s_resp !== 1'b1 || s_inst_valid !== 1'b1 || s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_setup: got resp %b iv %b rv %b want 1 1 0", s_resp,
                     s_inst_valid, s_req_valid);
        end
        tick();
        n_checks++;
        if (s_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_flush: got inst_valid %b want 0", s_inst_valid);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = s_inst_valid;
        end
        n_checks++;
        if (!seen || s_inst_pc !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL collision_first_pc: got %h (valid %0d) want 00002000", s_inst_pc, seen);
        end
    endtask

    task automatic test_halt();
        logic [31:0] next_addr = '0;
        int nreq = 0, npop = 0;
        drain();
        mem_hold = 1'b1; halt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (s_req) begin nreq++; next_addr = s_addr + 32'd4; end
        end
        halt = 1'b1; mem_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_req) nreq++;
            if (s_inst_valid) npop++;
        end
        n_checks++;
        if (nreq != 2 || npop != 2) begin
            n_fail++;
            $display("FAIL halt_hold: got %0d reqs %0d words want 2 2", nreq, npop);
        end
        halt = 1'b0;
        tick();
        n_checks++;
        if (s_req_valid !== 1'b1 || s_addr !== next_addr) begin
            n_fail++;
            $display("FAIL halt_resume: got %b %h want 1 %h", s_req_valid, s_addr, next_addr);
        end
    endtask

    task automatic test_wrap_and_reset();
        drain();
        halt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got %b %h want 1 fffffffc", s_req, s_addr);
        end
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_second: got %b %h want 1 00000000", s_req, s_addr);
        end
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst_data !== 32'h0 ||
            inst_pc !== 32'h0 || imem_req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL async_reset: got iv %b rv %b d %h pc %h a %h want 0 0 0 0 %h",
                     inst_valid, imem_req_valid, inst_data, inst_pc, imem_req_addr, RESET_PC);
        end
        tick();
        tick();
        halt = 1'b1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int npop = 0;
        resp_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            halt           = ($urandom_range(7, 0) == 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = $urandom();
            imem_req_ready = $urandom_range(1, 0) == 1;
            inst_ready     = ($urandom_range(3, 0) != 0);
            tick();
            if (s_inst_valid && s_iready && !s_redir) npop++;
        end
        n_checks++;
        if (npop < 100) begin
            n_fail++;
            $display("FAIL random_progress: got %0d words want at least 100", npop);
        end
        drain();
        n_checks++;
        if (s_inst_valid !== 1'b0 || s_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL random_idle: got iv %b rv %b want 0 0", s_inst_valid, s_req_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_collision();
        test_halt();
        test_wrap_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
